// File: rtl/cordic.sv
`default_nettype none
// ============================================================================
// Module   : cordic
// Brief    : Iterative rotation-mode CORDIC, Q8.8 degrees in -> Q1.15 cos/sin
//            out, one micro-rotation per clock, pulse handshake.
// Revision : 1.0 - initial release
// ============================================================================

module cordic #(
  parameter int iterations = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               input_ready,
  input  logic [15:0]        angle,
  output logic               output_ready,
  output logic signed [15:0] cosine_out,
  output logic signed [15:0] sine_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  localparam logic [15:0]        c_deg90     = 16'd23040;
  localparam logic [15:0]        c_deg180    = 16'd46080;
  localparam logic signed [19:0] c_k         = 20'sd79594;
  localparam logic [4:0]         c_last_iter = 5'(iterations - 1);

  state_t             r_state;
  logic [4:0]         r_cnt;
  logic signed [19:0] r_x;
  logic signed [19:0] r_y;
  logic signed [31:0] r_z;
  logic               r_neg_cos;
  logic               r_neg_sin;

  logic               w_q2;
  logic               w_q3;
  logic [15:0]        w_folded;
  logic signed [31:0] w_z_init;
  logic signed [19:0] w_x_sh;
  logic signed [19:0] w_y_sh;
  logic signed [31:0] w_atan;
  logic signed [19:0] w_x_nxt;
  logic signed [19:0] w_y_nxt;
  logic signed [31:0] w_z_nxt;
  logic signed [15:0] w_cos_sat;
  logic signed [15:0] w_sin_sat;
  logic signed [15:0] w_cos_res;
  logic signed [15:0] w_sin_res;

  // atan(2^-i) in degrees scaled by 2^24
  function automatic logic signed [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    return 32'sd754974720;
      5'd1:    return 32'sd445687602;
      5'd2:    return 32'sd235489088;
      5'd3:    return 32'sd119537938;
      5'd4:    return 32'sd60000934;
      5'd5:    return 32'sd30029717;
      5'd6:    return 32'sd15018523;
      5'd7:    return 32'sd7509720;
      5'd8:    return 32'sd3754917;
      5'd9:    return 32'sd1877466;
      5'd10:   return 32'sd938734;
      5'd11:   return 32'sd469367;
      5'd12:   return 32'sd234684;
      5'd13:   return 32'sd117342;
      5'd14:   return 32'sd58671;
      5'd15:   return 32'sd29335;
      5'd16:   return 32'sd14668;
      5'd17:   return 32'sd7334;
      5'd18:   return 32'sd3667;
      5'd19:   return 32'sd1833;
      5'd20:   return 32'sd917;
      5'd21:   return 32'sd458;
      5'd22:   return 32'sd229;
      5'd23:   return 32'sd115;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] sat_round(input logic signed [19:0] v);
    logic signed [19:0] t;
    t = (v + 20'sd2) >>> 2;
    if (t > 20'sd32767)
      return 16'sh7fff;
    if (t < -20'sd32768)
      return 16'sh8000;
    return t[15:0];
  endfunction

  // Negating full-scale negative would wrap, so clamp it to full-scale positive
  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] v);
    if (v == 16'sh8000)
      return 16'sh7fff;
    return -v;
  endfunction

  always_comb begin
    w_q2     = (angle > c_deg90) && (angle <= c_deg180);
    w_q3     = (angle > c_deg180);
    w_folded = angle;
    if (w_q3)
      w_folded = angle - c_deg180;
    else if (w_q2)
      w_folded = c_deg180 - angle;
    w_z_init = {w_folded, 16'h0000};
  end

  always_comb begin
    w_x_sh = r_x >>> r_cnt;
    w_y_sh = r_y >>> r_cnt;
    w_atan = atan_lut(r_cnt);
    if (!r_z[31]) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  always_comb begin
    w_cos_sat = sat_round(r_x);
    w_sin_sat = sat_round(r_y);
    w_cos_res = r_neg_cos ? neg_sat(w_cos_sat) : w_cos_sat;
    w_sin_res = r_neg_sin ? neg_sat(w_sin_sat) : w_sin_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_neg_cos    <= 1'b0;
      r_neg_sin    <= 1'b0;
      output_ready <= 1'b0;
      cosine_out   <= '0;
      sine_out     <= '0;
    end else begin
      output_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (input_ready) begin
            r_x       <= c_k;
            r_y       <= '0;
            r_z       <= w_z_init;
            r_neg_cos <= w_q2 | w_q3;
            r_neg_sin <= w_q3;
            r_cnt     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (r_cnt == c_last_iter)
            r_state <= S_FINAL;
          else
            r_cnt <= r_cnt + 5'd1;
        end
        S_FINAL: begin
          cosine_out   <= w_cos_res;
          sine_out     <= w_sin_res;
          output_ready <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic
// Brief    : Randomised self-checking bench for cordic against a real-valued
//            cos/sin reference.
// Revision : 1.0 - initial release
// ============================================================================

module tb_cordic;

  localparam int ITER = 16;
  localparam int TOL  = 4;
  localparam int LAT  = ITER + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               input_ready;
  logic [15:0]        angle;
  logic               output_ready;
  logic signed [15:0] cosine_out;
  logic signed [15:0] sine_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic #(.iterations(ITER)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_ready  (input_ready),
    .angle        (angle),
    .output_ready (output_ready),
    .cosine_out   (cosine_out),
    .sine_out     (sine_out)
  );

  // Ideal rounded Q1.15 value of cos or sin of a Q8.8 degree angle
  function automatic int ref_val(input logic [15:0] a, input bit is_sin);
    real rad, v;
    int  r;
    rad = (real'(a) / 256.0) * 3.14159265358979323846 / 180.0;
    v   = (is_sin ? $sin(rad) : $cos(rad)) * 32768.0;
    r   = $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Called on a negedge; returns on the negedge right after the accept edge
  task automatic start_op(input logic [15:0] a);
    angle       = a;
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    angle       = 16'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (output_ready !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if (output_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: got %b want 0", output_ready);
    end
    n_vec++;
    if (cosine_out !== 16'sd0) begin
      n_err++; $display("FAIL reset_cos: got %0d want 0", cosine_out);
    end
    n_vec++;
    if (sine_out !== 16'sd0) begin
      n_err++; $display("FAIL reset_sin: got %0d want 0", sine_out);
    end
  endtask

  task automatic test_45;
    int lat, dc, ds;
    start_op(16'd11520);
    wait_done(lat);
    n_vec++;
    if (lat != LAT) begin
      n_err++; $display("FAIL lat45: got %0d want %0d", lat, LAT);
    end
    dc = int'(cosine_out) - ref_val(16'd11520, 1'b0);
    ds = int'(sine_out)   - ref_val(16'd11520, 1'b1);
    n_vec++;
    if (dc > TOL || dc < -TOL) begin
      n_err++; $display("FAIL cos45: got %0d want %0d", cosine_out, ref_val(16'd11520, 1'b0));
    end
    n_vec++;
    if (ds > TOL || ds < -TOL) begin
      n_err++; $display("FAIL sin45: got %0d want %0d", sine_out, ref_val(16'd11520, 1'b1));
    end
    @(negedge clk);
    n_vec++;
    if (output_ready !== 1'b0) begin
      n_err++; $display("FAIL pulse_width: got %b want 0", output_ready);
    end
    repeat (5) @(negedge clk);
    dc = int'(cosine_out) - ref_val(16'd11520, 1'b0);
    n_vec++;
    if (dc > TOL || dc < -TOL) begin
      n_err++; $display("FAIL hold45: got %0d want %0d", cosine_out, ref_val(16'd11520, 1'b0));
    end
  endtask

  // Directed and random angles, each started in the output_ready cycle of the previous one
  task automatic test_back_to_back(input int n_rand);
    logic [15:0] list[$];
    int lat, dc, ds;
    list = '{16'd2560, 16'd7680, 16'd0, 16'd23040, 16'd46080, 16'd38400, 16'd53760,
             16'd65535, 16'd23041, 16'd46081};
    for (int i = 0; i < n_rand; i++) list.push_back(16'($urandom_range(0, 65535)));
    @(negedge clk);
    foreach (list[i]) begin
      start_op(list[i]);
      wait_done(lat);
      n_vec++;
      if (lat != LAT) begin
        n_err++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, LAT);
      end
      dc = int'(cosine_out) - ref_val(list[i], 1'b0);
      ds = int'(sine_out)   - ref_val(list[i], 1'b1);
      n_vec++;
      if (dc > TOL || dc < -TOL) begin
        n_err++; $display("FAIL b2b_cos angle=%0d: got %0d want %0d", list[i], cosine_out, ref_val(list[i], 1'b0));
      end
      n_vec++;
      if (ds > TOL || ds < -TOL) begin
        n_err++; $display("FAIL b2b_sin angle=%0d: got %0d want %0d", list[i], sine_out, ref_val(list[i], 1'b1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_busy;
    int lat, dc, ds, pulses;
    start_op(16'd7680);
    repeat (4) @(negedge clk);
    angle       = 16'd15360;
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    wait_done(lat);
    n_vec++;
    if (lat != LAT - 5) begin
      n_err++; $display("FAIL busy_lat: got %0d want %0d", lat, LAT - 5);
    end
    dc = int'(cosine_out) - ref_val(16'd7680, 1'b0);
    ds = int'(sine_out)   - ref_val(16'd7680, 1'b1);
    n_vec++;
    if (dc > TOL || dc < -TOL) begin
      n_err++; $display("FAIL busy_cos: got %0d want %0d", cosine_out, ref_val(16'd7680, 1'b0));
    end
    n_vec++;
    if (ds > TOL || ds < -TOL) begin
      n_err++; $display("FAIL busy_sin: got %0d want %0d", sine_out, ref_val(16'd7680, 1'b1));
    end
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (output_ready === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL busy_extra: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, dc;
    start_op(16'd11520);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (cosine_out !== 16'sd0 || sine_out !== 16'sd0 || output_ready !== 1'b0) begin
      n_err++; $display("FAIL midrst_out: got cos=%0d sin=%0d rdy=%b want 0 0 0", cosine_out, sine_out, output_ready);
    end
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (output_ready === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 0) begin
      n_err++; $display("FAIL midrst_pulse: got %0d pulses want 0", pulses);
    end
    start_op(16'd15360);
    wait_done(lat);
    n_vec++;
    if (lat != LAT) begin
      n_err++; $display("FAIL midrst_lat: got %0d want %0d", lat, LAT);
    end
    dc = int'(sine_out) - ref_val(16'd15360, 1'b1);
    n_vec++;
    if (dc > TOL || dc < -TOL) begin
      n_err++; $display("FAIL midrst_sin: got %0d want %0d", sine_out, ref_val(16'd15360, 1'b1));
    end
    @(negedge clk);
  endtask

  // Strobe held over 25 edges: one op, then a second accepted on return to IDLE
  task automatic test_held_strobe;
    int pulses, dc;
    pulses      = 0;
    angle       = 16'd30000;
    input_ready = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (output_ready === 1'b1) pulses++;
    end
    input_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (output_ready === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++; $display("FAIL held_pulses: got %0d want 2", pulses);
    end
    dc = int'(cosine_out) - ref_val(16'd30000, 1'b0);
    n_vec++;
    if (dc > TOL || dc < -TOL) begin
      n_err++; $display("FAIL held_cos: got %0d want %0d", cosine_out, ref_val(16'd30000, 1'b0));
    end
  endtask

  initial begin
    rst         = 1'b1;
    input_ready = 1'b0;
    angle       = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_45;
    test_back_to_back(24);
    test_busy;
    test_reset_mid;
    test_held_strobe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
